// File: rtl/sync_wc_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_wc_fifo_pkg
// Shared helpers for the single-clock width-converting FIFO:
//   - clog2               : ceiling log2 for elaboration-time arithmetic
//   - unit_w              : storage unit width, min(DWI,DWO)
//   - ratio_r             : max(DWI,DWO)/min(DWI,DWO)
//   - units_per_write     : WU, storage units consumed by one write
//   - units_per_read      : RU, storage units produced by one read
//   - widths_legal        : power-of-two widths whose ratio divides the depth
//   - thresholds_legal    : programmable thresholds within 0..2^AWU
// -----------------------------------------------------------------------------
package sync_wc_fifo_pkg;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 32'sd1;
        r = 32'sd0;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 1;
        end
        return r;
    endfunction

    function automatic int unit_w(input int dwi, input int dwo);
        return (dwi < dwo) ? dwi : dwo;
    endfunction

    function automatic int ratio_r(input int dwi, input int dwo);
        return ((dwi > dwo) ? dwi : dwo) / unit_w(dwi, dwo);
    endfunction

    function automatic int units_per_write(input int dwi, input int dwo);
        return dwi / unit_w(dwi, dwo);
    endfunction

    function automatic int units_per_read(input int dwi, input int dwo);
        return dwo / unit_w(dwi, dwo);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
    endfunction

    // A wide access must fit inside the array so it never straddles the wrap.
    function automatic bit widths_legal(input int dwi, input int dwo, input int awu);
        return is_pow2(dwi) && is_pow2(dwo) && (awu > 32'sd0) &&
               (clog2(ratio_r(dwi, dwo)) <= awu);
    endfunction

    function automatic bit thresholds_legal(input int awu, input int pf, input int pe);
        return (pf >= 32'sd0) && (pe >= 32'sd0) &&
               (pf <= (32'sd1 <<< awu)) && (pe <= (32'sd1 <<< awu));
    endfunction

endpackage

// File: rtl/ramdp_asym.sv
// -----------------------------------------------------------------------------
// ramdp_asym
// Single-clock asymmetric register array of 2^AWU units of UW bits.
// Write port stores WU consecutive units per access, read port returns RU
// consecutive units combinationally. Lowest address maps to the LSB slice.
// The array is deliberately not reset.
// Ports:
//   clk    : clock, rising edge
//   we     : write enable
//   waddr  : unit address of the lowest written unit
//   wdata  : WU*UW bits of write data
//   raddr  : unit address of the lowest read unit
//   rdata  : RU*UW bits of read data (combinational)
// -----------------------------------------------------------------------------
module ramdp_asym #(
    parameter int UW  = 4,
    parameter int AWU = 6,
    parameter int WU  = 1,
    parameter int RU  = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AWU-1:0]      waddr,
    input  logic [WU*UW-1:0]    wdata,
    input  logic [AWU-1:0]      raddr,
    output logic [RU*UW-1:0]    rdata
);

    localparam int DEPTH = 32'sd1 <<< AWU;

    logic [UW-1:0] mem_r [DEPTH];

    // Store each write slice at consecutive unit addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WU; i++) begin
                mem_r[waddr + AWU'(i)] <= wdata[i*UW +: UW];
            end
        end
    end

    // Gather RU consecutive units into one read word.
    always_comb begin
        rdata = {(RU*UW){1'b0}};
        for (int i = 0; i < RU; i++) begin
            rdata[i*UW +: UW] = mem_r[raddr + AWU'(i)];
        end
    end

endmodule

// File: rtl/sync_wc_fifo.sv
// -----------------------------------------------------------------------------
// sync_wc_fifo
// Single-clock width-converting FIFO (upsizing or downsizing by a power-of-two
// ratio) with fill level, programmable thresholds and overflow/underflow pulses.
// Compile-time option:
//   FIFO_FWFT_EN : defined  -> first-word-fall-through read data
//                  undefined-> read data registered at the accepting edge
// Ports:
//   clk, rstn         : clock (rising edge), asynchronous active-low reset
//   winc, wdata       : write request and DWI-bit data
//   rinc, rdata       : read request and DWO-bit data
//   wfull, rempty     : fewer than WU free / RU stored units
//   prog_full/empty   : count >= PROG_FULL / count <= PROG_EMPTY
//   count             : stored units (AWU+1 bits)
//   wovf, rund        : one-cycle pulses for dropped writes / reads
// -----------------------------------------------------------------------------
module sync_wc_fifo
    import sync_wc_fifo_pkg::*;
#(
    parameter int DWI        = 4,
    parameter int DWO        = 16,
    parameter int AWU        = 6,
    parameter int PROG_FULL  = 48,
    parameter int PROG_EMPTY = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            winc,
    input  logic [DWI-1:0]  wdata,
    input  logic            rinc,
    output logic [DWO-1:0]  rdata,
    output logic            wfull,
    output logic            rempty,
    output logic            prog_full,
    output logic            prog_empty,
    output logic [AWU:0]    count,
    output logic            wovf,
    output logic            rund
);

    localparam int UW    = unit_w(DWI, DWO);
    localparam int WU    = units_per_write(DWI, DWO);
    localparam int RU    = units_per_read(DWI, DWO);
    localparam int DEPTH = 32'sd1 <<< AWU;

    localparam logic [AWU:0]   FULL_LIM = (AWU+1)'(DEPTH - WU);
    localparam logic [AWU:0]   WU_INC   = (AWU+1)'(WU);
    localparam logic [AWU:0]   RU_DEC   = (AWU+1)'(RU);
    localparam logic [AWU:0]   PF_LIM   = (AWU+1)'(PROG_FULL);
    localparam logic [AWU:0]   PE_LIM   = (AWU+1)'(PROG_EMPTY);
    localparam logic [AWU-1:0] WP_STEP  = AWU'(WU);
    localparam logic [AWU-1:0] RP_STEP  = AWU'(RU);

    if (!widths_legal(DWI, DWO, AWU)) begin : g_bad_widths
        $error("sync_wc_fifo: DWI/DWO must be powers of two with a ratio not exceeding the depth");
    end
    if (!thresholds_legal(AWU, PROG_FULL, PROG_EMPTY)) begin : g_bad_thresholds
        $error("sync_wc_fifo: PROG_FULL/PROG_EMPTY must lie within 0..2^AWU");
    end

    logic [AWU:0]    count_r;
    logic [AWU-1:0]  wptr_r;
    logic [AWU-1:0]  rptr_r;
    logic            wovf_r;
    logic            rund_r;
    logic            wfull_s;
    logic            rempty_s;
    logic            wacc_s;
    logic            racc_s;
    logic [AWU:0]    cnt_add_s;
    logic [AWU:0]    cnt_sub_s;
    logic [AWU:0]    cnt_nxt_s;
    logic [DWO-1:0]  mem_rdata_s;

    // Both requests are judged against the current flags, never the next ones.
    assign wfull_s  = (count_r > FULL_LIM);
    assign rempty_s = (count_r < RU_DEC);
    assign wacc_s   = winc & ~wfull_s;
    assign racc_s   = rinc & ~rempty_s;

    // Next fill level from accepted accesses only.
    always_comb begin
        cnt_add_s = wacc_s ? WU_INC : {(AWU+1){1'b0}};
        cnt_sub_s = racc_s ? RU_DEC : {(AWU+1){1'b0}};
        cnt_nxt_s = count_r + cnt_add_s - cnt_sub_s;
    end

    // Pointer, fill level and dropped-request pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= {(AWU+1){1'b0}};
            wptr_r  <= {AWU{1'b0}};
            rptr_r  <= {AWU{1'b0}};
            wovf_r  <= 1'b0;
            rund_r  <= 1'b0;
        end else begin
            count_r <= cnt_nxt_s;
            if (wacc_s) begin
                wptr_r <= wptr_r + WP_STEP;
            end
            if (racc_s) begin
                rptr_r <= rptr_r + RP_STEP;
            end
            wovf_r <= winc & wfull_s;
            rund_r <= rinc & rempty_s;
        end
    end

    ramdp_asym #(
        .UW  (UW),
        .AWU (AWU),
        .WU  (WU),
        .RU  (RU)
    ) u_mem (
        .clk   (clk),
        .we    (wacc_s),
        .waddr (wptr_r),
        .wdata (wdata),
        .raddr (rptr_r),
        .rdata (mem_rdata_s)
    );

`ifdef FIFO_FWFT_EN
    // Head word falls through; forced to zero while nothing complete is stored.
    assign rdata = rempty_s ? {DWO{1'b0}} : mem_rdata_s;
`else
    logic [DWO-1:0] rdata_r;

    // Capture the head word at the edge that accepts the read; hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_r <= {DWO{1'b0}};
        end else if (racc_s) begin
            rdata_r <= mem_rdata_s;
        end
    end

    assign rdata = rdata_r;
`endif

    assign wfull      = wfull_s;
    assign rempty     = rempty_s;
    assign prog_full  = (count_r >= PF_LIM);
    assign prog_empty = (count_r <= PE_LIM);
    assign count      = count_r;
    assign wovf       = wovf_r;
    assign rund       = rund_r;

endmodule

// File: doc/sync_wc_fifo.md
# sync_wc_fifo

Single-clock, width-converting FIFO: the synchronous successor to our asynchronous width-converting FIFO, for width adaptation inside one clock domain. It supports both upsizing (narrow in, wide out) and downsizing (wide in, narrow out) from one parameter set. It also provides a fill-level output, programmable full and empty thresholds, and overflow/underflow pulses. It sits between datapath stages whose bus widths differ by a power-of-two ratio.

## Interface
Parameters:
- DWI, 4: write data width, bits.
- DWO, 16: read data width, bits. DWI and DWO must be powers of two, and one must be a multiple of the other.
- AWU, 6: address width in storage units. A storage unit is min(DWI,DWO) bits. Depth is 2^AWU units.
- PROG_FULL, 48: prog_full threshold, in units.
- PROG_EMPTY, 4: prog_empty threshold, in units.

Ports:
- clk, input, 1: single clock, rising edge.
- rstn, input, 1: asynchronous, active-low reset.
- winc, input, 1: write request.
- wdata, input, DWI: write data.
- rinc, input, 1: read request.
- rdata, output, DWO: read data.
- wfull, output, 1: fewer than WU free units remain.
- rempty, output, 1: fewer than RU stored units remain.
- prog_full, output, 1: count >= PROG_FULL.
- prog_empty, output, 1: count <= PROG_EMPTY.
- count, output, AWU+1: stored units.
- wovf, output, 1: one-cycle pulse, write attempted while wfull.
- rund, output, 1: one-cycle pulse, read attempted while rempty.

## Operation
- Unit definitions:
  - R = max(DWI,DWO)/min(DWI,DWO).
  - WU = DWI/min(DWI,DWO) units per write.
  - RU = DWO/min(DWI,DWO) units per read.
  - One of WU and RU equals 1; the other equals R.
- Write accepted when winc & !wfull. It stores WU units at wptr, with the LSB slice at the lowest address. wptr advances by WU.
- Read accepted when rinc & !rempty. It consumes RU units at rptr. The lowest-address unit goes to rdata LSBs. rptr advances by RU.
- Packing is little-endian in both directions:
  - Upsizing: the first nibble written appears in rdata[3:0].
  - Downsizing: wdata[3:0] is read first.
- Pointers are AWU-bit unit addresses and wrap modulo 2^AWU. WU and RU divide the depth, so wide accesses never straddle the wrap.
- Count update: count_next = count + WU·wacc − RU·racc, in AWU+1 bits. It never exceeds 2^AWU and never goes below 0.
- Flags are combinational functions of the registered count:
  - wfull = (count > 2^AWU − WU)
  - rempty = (count < RU)
- Simultaneous read and write are both evaluated against the current flags, not the next ones.
  - A write while wfull is dropped even if a read is accepted in the same cycle. The same rule holds symmetrically for reads.
- A dropped request leaves pointers and count unchanged and raises wovf or rund for one cycle.
- Storage is a flop array of 2^AWU units. It is not reset.

## Timing
- Reset values:
  - count = 0, rempty = 1, wfull = 0, prog_empty = 1, prog_full = 0.
  - wovf = 0, rund = 0, rdata = 0.
  - Both pointers = 0.
- Assertion of rstn at any time clears state immediately. Data present before reset is lost.
- Write latency: a write accepted at edge N is included in count, flags and readable data after edge N, i.e. visible during cycle N+1.
- Read latency with the default build: rdata is registered and updated at the accepting edge. It is valid from the following cycle and holds until the next accepted read.
- wovf and rund are registered. They assert during the cycle after the offending edge.

## Configuration
- FIFO_FWFT_EN:
  - Defined: first-word-fall-through. rdata combinationally presents the head RU units whenever rempty = 0. An accepted rinc advances to the next word. rdata is 0 while empty.
  - Undefined: registered read behaviour as described under Timing.
- Flags, count and pulse timing are identical in both builds.

## Structure
- Package sync_wc_fifo_pkg holds:
  - the ratio/unit helper functions for R, WU and RU;
  - the clog2 function;
  - elaboration-time checks for illegal DWI/DWO ratios and for thresholds greater than 2^AWU.
- Sub-module ramdp_asym: a single-clock asymmetric-port register array. It has a WU-unit write port and an RU-unit read port, with combinational read. The FIFO adds the optional output register.

## Test plan
- Upsizing, DWI=4, DWO=16, default build:
  - Write nibbles 1, 2, 3; rempty stays 1.
  - Write 4; rempty = 0 the next cycle.
  - rinc; rdata = 0x4321 the cycle after.
- Full and overflow:
  - Write 64 nibbles; wfull = 1 and count = 64.
  - 65th write: dropped, wovf pulses once.
  - Read one word; count = 60, wfull = 0.
- Simultaneous, at count = 64:
  - winc & rinc in the same cycle: the read is accepted, the write is dropped, count = 60, wovf = 1.
  - At count = 32, both requests are accepted and count = 29.
- Downsizing, DWI=16, DWO=4, with FIFO_FWFT_EN defined:
  - Write 0xABCD; rdata shows 0xD with no rinc.
  - Successive rinc steps rdata through 0xC, 0xB, 0xA; rempty = 1 after the fourth.
- Thresholds and wrap:
  - Stream 200 words with random winc/rinc. Check data order against a model.
  - prog_full toggles at count 48, prog_empty at count 4.
  - rund pulses on every read attempted while empty.
- Reset mid-operation:
  - With count = 20, pulse rstn low.
  - All outputs return to their reset values immediately.
  - The next write followed by a read returns only the new data.
